// File: rtl/stage_mem_if.sv
// rtl/stage_mem_if.sv - data memory bus between stage_mem (master) and memory (slave)
interface stage_mem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - pipeline memory stage: IDLE/REQ bus FSM, load extend, store lanes
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of aligning down.
module stage_mem (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        exResult_in,
  input  logic [31:0]        rs2Data_in,
  input  logic [4:0]         memOp_in,
  input  logic [5:0]         wdOp_in,
  output logic               stall_out,
  output logic [31:0]        wbData_out,
  output logic [5:0]         wdOp_out,
  output logic               misalign_out,
  stage_mem_if.master        dmem
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state, state_nx;
  logic        accept, complete, trap, misaligned;
  logic        is_word, is_half;
  logic [1:0]  offset;
  logic [3:0]  strb;
  logic [31:0] lanes;

  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [5:0]  wdop_q;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign is_word = memOp_in[3];
  assign is_half = (memOp_in[3:2] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = (is_half & exResult_in[0]) | (is_word & (|exResult_in[1:0]));
`else
  assign misaligned = 1'b0;
`endif

  // Byte offset of the accessed lane; unaligned low bits are dropped for half/word.
  always_comb begin
    offset = exResult_in[1:0];
    strb   = 4'b0001 << exResult_in[1:0];
    lanes  = {4{rs2Data_in[7:0]}};
    if (is_word) begin
      offset = 2'b00;
      strb   = 4'b1111;
      lanes  = rs2Data_in;
    end else if (is_half) begin
      offset = {exResult_in[1], 1'b0};
      strb   = exResult_in[1] ? 4'b1100 : 4'b0011;
      lanes  = {2{rs2Data_in[15:0]}};
    end
    if (!memOp_in[1])
      strb = 4'b0000;
  end

  always_comb begin
    shifted  = dmem.dmem_rdata >> {off_q, 3'b000};
    load_val = shifted;
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_nx  = state;
    stall_out = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    trap      = 1'b0;
    case (state)
      IDLE: begin
        if (memOp_in[0]) begin
          if (misaligned) begin
            trap = 1'b1;
          end else begin
            accept    = 1'b1;
            stall_out = 1'b1;
            state_nx  = REQ;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_ack) begin
          complete = 1'b1;
          state_nx = IDLE;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_wdata <= 32'd0;
      dmem.dmem_wstrb <= 4'd0;
      wbData_out      <= 32'd0;
      wdOp_out        <= 6'd0;
      size_q          <= 2'd0;
      uns_q           <= 1'b0;
      off_q           <= 2'd0;
      wdop_q          <= 6'd0;
    end else if (accept) begin
      dmem.dmem_req   <= 1'b1;
      dmem.dmem_we    <= memOp_in[1];
      dmem.dmem_addr  <= {exResult_in[31:2], 2'b00};
      dmem.dmem_wdata <= lanes;
      dmem.dmem_wstrb <= strb;
      size_q          <= memOp_in[3:2];
      uns_q           <= memOp_in[4];
      off_q           <= offset;
      wdop_q          <= wdOp_in;
      wdOp_out        <= 6'd0;
    end else if (complete) begin
      // Stores retire as a bubble; loads carry the extended read data.
      dmem.dmem_req <= 1'b0;
      wbData_out    <= dmem.dmem_we ? 32'd0 : load_val;
      wdOp_out      <= dmem.dmem_we ? 6'd0 : wdop_q;
    end else if (state == REQ) begin
      wdOp_out <= 6'd0;
    end else if (trap) begin
      wbData_out <= exResult_in;
      wdOp_out   <= 6'd0;
    end else begin
      wbData_out <= exResult_in;
      wdOp_out   <= wdOp_in;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)
      misalign_out <= 1'b0;
    else
      misalign_out <= trap;
  end
`else
  assign misalign_out = 1'b0;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - randomized bench for stage_mem against a transaction-level model
module tb_stage_mem;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exResult_in, rs2Data_in;
  logic [4:0]  memOp_in;
  logic [5:0]  wdOp_in;
  logic        stall_out;
  logic [31:0] wbData_out;
  logic [5:0]  wdOp_out;
  logic        misalign_out;

  stage_mem_if bus ();

  stage_mem dut (
    .clk          (clk),
    .rst          (rst),
    .exResult_in  (exResult_in),
    .rs2Data_in   (rs2Data_in),
    .memOp_in     (memOp_in),
    .wdOp_in      (wdOp_in),
    .stall_out    (stall_out),
    .wbData_out   (wbData_out),
    .wdOp_out     (wdOp_out),
    .misalign_out (misalign_out),
    .dmem         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected visible outputs for the current cycle
  logic        e_stall, e_req, e_we, e_mis;
  logic [31:0] e_addr, e_wdata, e_wb;
  logic [3:0]  e_wstrb;
  logic [5:0]  e_wdop;
  logic        chk_en = 1'b0;
  logic        chk_stall = 1'b1;

  // Per-transaction captures used for literal checks
  int          cap_stall_n;
  logic        cap_req, cap_mis;
  logic [31:0] cap_addr, cap_wdata, cap_wb;
  logic [3:0]  cap_wstrb;
  logic [5:0]  cap_wdop;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (chk_stall) cmp("stall_out", {31'd0, stall_out}, {31'd0, e_stall});
      cmp("dmem_req", {31'd0, bus.dmem_req}, {31'd0, e_req});
      if (e_req) begin
        cmp("dmem_we", {31'd0, bus.dmem_we}, {31'd0, e_we});
        cmp("dmem_addr", bus.dmem_addr, e_addr);
        cmp("dmem_wstrb", {28'd0, bus.dmem_wstrb}, {28'd0, e_wstrb});
        if (e_we) cmp("dmem_wdata", bus.dmem_wdata, e_wdata);
      end
      cmp("wbData_out", wbData_out, e_wb);
      cmp("wdOp_out", {26'd0, wdOp_out}, {26'd0, e_wdop});
      cmp("misalign_out", {31'd0, misalign_out}, {31'd0, e_mis});
    end
  end

  function automatic bit f_mis(input logic [4:0] m, input logic [31:0] a);
    if (!TRAP) return 1'b0;
    return (m[3:2] == 2'b01 && a[0]) || (m[3] && a[1:0] != 2'b00);
  endfunction

  function automatic int f_off(input logic [4:0] m, input logic [31:0] a);
    if (m[3]) return 0;
    if (m[2]) return a[1] ? 2 : 0;
    return int'(a[1:0]);
  endfunction

  function automatic logic [3:0] f_strb(input logic [4:0] m, input logic [31:0] a);
    if (!m[1]) return 4'b0000;
    if (m[3]) return 4'b1111;
    if (m[2]) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b0001 << a[1:0];
  endfunction

  function automatic logic [31:0] f_wdata(input logic [4:0] m, input logic [31:0] d);
    if (m[3]) return d;
    if (m[2]) return {d[15:0], d[15:0]};
    return {d[7:0], d[7:0], d[7:0], d[7:0]};
  endfunction

  function automatic logic [31:0] f_load(input logic [4:0] m, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * f_off(m, a));
    if (m[3]) return v;
    if (m[2]) begin
      v = v & 32'h0000_FFFF;
      if (!m[4] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = v & 32'h0000_00FF;
      if (!m[4] && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_stall();
    #1;
    cap_stall_n += int'(stall_out);
  endtask

  task automatic run_op(input logic [31:0] exr, input logic [31:0] rs2, input logic [4:0] mop,
                        input logic [5:0] wdop, input int delay, input logic [31:0] rdata);
    exResult_in = exr;
    rs2Data_in  = rs2;
    memOp_in    = mop;
    wdOp_in     = wdop;
    cap_stall_n = 0;
    cap_req     = 1'b0;
    bus.dmem_ack   = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    if (!mop[0]) begin
      e_stall = 1'b0;
      count_stall();
      tick();
      e_mis = 1'b0; e_wb = exr; e_wdop = wdop;
    end else if (f_mis(mop, exr)) begin
      e_stall = 1'b0;
      count_stall();
      tick();
      e_mis = 1'b1; e_wb = exr; e_wdop = 6'd0;
    end else begin
      e_stall = 1'b1;
      count_stall();
      tick();
      e_mis = 1'b0; e_req = 1'b1; e_we = mop[1];
      e_addr = {exr[31:2], 2'b00};
      e_wstrb = f_strb(mop, exr);
      e_wdata = f_wdata(mop, rs2);
      e_wdop = 6'd0;
      cap_req = bus.dmem_req; cap_addr = bus.dmem_addr;
      cap_wstrb = bus.dmem_wstrb; cap_wdata = bus.dmem_wdata;
      bus.dmem_ack = 1'b0;
      for (int k = 0; k < delay; k++) begin
        e_stall = 1'b1;
        count_stall();
        tick();
      end
      bus.dmem_ack = 1'b1;
      bus.dmem_rdata = rdata;
      e_stall = 1'b0;
      count_stall();
      tick();
      bus.dmem_ack = 1'b0;
      e_req = 1'b0;
      e_wb = mop[1] ? 32'd0 : f_load(mop, exr, rdata);
      e_wdop = mop[1] ? 6'd0 : wdop;
    end
    cap_wb = wbData_out; cap_wdop = wdOp_out; cap_mis = misalign_out;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_req"}, {31'd0, bus.dmem_req}, 32'd0);
    cmp({tag, "_we"}, {31'd0, bus.dmem_we}, 32'd0);
    cmp({tag, "_addr"}, bus.dmem_addr, 32'd0);
    cmp({tag, "_wdata"}, bus.dmem_wdata, 32'd0);
    cmp({tag, "_wstrb"}, {28'd0, bus.dmem_wstrb}, 32'd0);
    cmp({tag, "_wb"}, wbData_out, 32'd0);
    cmp({tag, "_wdop"}, {26'd0, wdOp_out}, 32'd0);
    cmp({tag, "_mis"}, {31'd0, misalign_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    exResult_in = '0; rs2Data_in = '0; memOp_in = '0; wdOp_in = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    repeat (2) tick();
    check_all_zero("reset");
    e_stall = 0; e_req = 0; e_we = 0; e_mis = 0;
    e_addr = 0; e_wdata = 0; e_wb = 0; e_wstrb = 0; e_wdop = 0;
    rst = 1'b0;
    chk_en = 1'b1;

    run_op(32'h1234, 32'd0, 5'b00000, 6'h0B, 0, 32'd0);
    cmp("nonmem_wb", cap_wb, 32'h1234);
    cmp("nonmem_wdop", {26'd0, cap_wdop}, 32'h0B);
    cmp("nonmem_stall", cap_stall_n, 0);

    run_op(32'h103, 32'd0, 5'b00001, 6'h11, 0, 32'h80FF_FF00);
    cmp("lb_addr", cap_addr, 32'h100);
    cmp("lb_wstrb", {28'd0, cap_wstrb}, 32'h0);
    cmp("lb_wb", cap_wb, 32'hFFFF_FF80);
    cmp("lb_wdop", {26'd0, cap_wdop}, 32'h11);
    cmp("lb_stall", cap_stall_n, 1);

    run_op(32'h103, 32'd0, 5'b10001, 6'h11, 0, 32'h80FF_FF00);
    cmp("lbu_wb", cap_wb, 32'h0000_0080);

    run_op(32'h202, 32'hDEAD_BEEF, 5'b00111, 6'h22, 3, 32'd0);
    cmp("sh_wstrb", {28'd0, cap_wstrb}, 32'hC);
    cmp("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    cmp("sh_stall", cap_stall_n, 4);
    cmp("sh_wb", cap_wb, 32'd0);
    cmp("sh_wdop", {26'd0, cap_wdop}, 32'd0);

    run_op(32'h301, 32'd0, 5'b01001, 6'h05, 1, 32'hCAFE_F00D);
    if (TRAP) begin
      cmp("lw_trap_req", {31'd0, cap_req}, 32'd0);
      cmp("lw_trap_mis", {31'd0, cap_mis}, 32'd1);
      cmp("lw_trap_wb", cap_wb, 32'h301);
      cmp("lw_trap_wdop", {26'd0, cap_wdop}, 32'd0);
    end else begin
      cmp("lw_addr", cap_addr, 32'h300);
      cmp("lw_wb", cap_wb, 32'hCAFE_F00D);
      cmp("lw_wdop", {26'd0, cap_wdop}, 32'h05);
    end

    // Reset while a request is outstanding, then a late ack
    exResult_in = 32'h400; memOp_in = 5'b01001; wdOp_in = 6'h07; bus.dmem_ack = 1'b0;
    e_stall = 1'b1;
    tick();
    e_mis = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 32'h400; e_wstrb = 4'd0; e_wdop = 6'd0;
    rst = 1'b1; chk_stall = 1'b0;
    tick();
    e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0; e_wb = 0; e_wdop = 0; e_mis = 0;
    check_all_zero("rstreq");
    rst = 1'b0; chk_stall = 1'b1;
    exResult_in = '0; memOp_in = '0; wdOp_in = '0;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    e_stall = 1'b0;
    tick();
    bus.dmem_ack = 1'b0;
    cmp("late_ack_req", {31'd0, bus.dmem_req}, 32'd0);
    cmp("late_ack_wb", wbData_out, 32'd0);
    cmp("late_ack_wdop", {26'd0, wdOp_out}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] m;
      m = 5'($urandom_range(0, 31));
      run_op($urandom, $urandom, m, 6'($urandom_range(0, 63)), $urandom_range(0, 3), $urandom);
    end

    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
